// File: rtl/htif_mailbox_pkg.sv
// Shared types for the HTIF mailbox: fromhost FSM
// state encodings and the default tohost depth.
package htif_mailbox_pkg;

  localparam int TOHOST_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    FH_IDLE       = 2'd0,
    FH_WRITE      = 2'd1,
    FH_WAIT_CLEAR = 2'd2
  } fh_state_t;

endpackage

// File: rtl/htif_mailbox_fifo.sv
// mbox_fifo: sync first-word-fall-through FIFO.
// Ports: push/wdata in, pop in, rdata/full/empty out.
module mbox_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam logic [PTR_W:0] FULL_CNT =
    (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/htif_mailbox.sv
// HTIF mailbox: tohost FIFO toward the host, and a
// fromhost FSM writing host words into PCR_FROMHOST.
// Ports: core tohost write + stall, host tohost and
// fromhost valid/ready channels, FROMHOST PCR write
// strobe/data, FROMHOST readback and irq.
module htif_mailbox
  import htif_mailbox_pkg::*;
#(
  parameter int TOHOST_DEPTH = TOHOST_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_stall,
  input  logic        tohost_we,
  input  logic [31:0] tohost_wdata,
  output logic        tohost_full_stall,
  output logic        host_tohost_valid,
  output logic [31:0] host_tohost_data,
  input  logic        host_tohost_ready,
  input  logic        host_fromhost_valid,
  input  logic [31:0] host_fromhost_data,
  output logic        host_fromhost_ready,
  output logic        fromhost_we,
  output logic [31:0] fromhost_wdata,
  input  logic [31:0] fromhost_value,
  output logic        fromhost_irq
);

  localparam int PTR_W = $clog2(TOHOST_DEPTH);

  logic th_full;
  logic th_empty;
  logic th_push;
  logic th_pop;

  // Fullness comes from registered state, so a
  // same-cycle pop never frees a slot for a push.
  assign th_push = tohost_we && !core_stall
                && !th_full;
  assign th_pop  = !th_empty && host_tohost_ready;

  assign tohost_full_stall = tohost_we && th_full;
  assign host_tohost_valid = !th_empty;

  mbox_fifo #(
    .DEPTH (TOHOST_DEPTH),
    .PTR_W (PTR_W),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (th_push),
    .wdata (tohost_wdata),
    .pop   (th_pop),
    .rdata (host_tohost_data),
    .full  (th_full),
    .empty (th_empty)
  );

  fh_state_t state;
  fh_state_t state_n;
  logic      fh_accept;

  assign fh_accept = host_fromhost_ready
                  && host_fromhost_valid;

  always_ff @(posedge clk) begin
    if (reset)
      state <= FH_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      FH_IDLE:
        if (host_fromhost_valid)
          state_n = FH_WRITE;
      FH_WRITE:
        if (!core_stall)
          state_n = FH_WAIT_CLEAR;
      FH_WAIT_CLEAR:
        if (fromhost_value == '0)
          state_n = FH_IDLE;
      default:
        state_n = FH_IDLE;
    endcase
  end

  // Ready is masked by reset so the host never sees
  // an accept while the mailbox is being cleared.
  always_comb begin
    host_fromhost_ready = 1'b0;
    fromhost_we         = 1'b0;
    fromhost_irq        = 1'b0;
    unique case (state)
      FH_IDLE:       host_fromhost_ready = !reset;
      FH_WRITE:      fromhost_we         = 1'b1;
      FH_WAIT_CLEAR: fromhost_irq        = 1'b1;
      default:       ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      fromhost_wdata <= '0;
    else if (fh_accept)
      fromhost_wdata <= host_fromhost_data;
  end

endmodule

// File: tb/tb_htif_mailbox.sv
// Scoreboard bench for htif_mailbox: directed vectors,
// expected words queued at issue, monitor compares.
module tb_htif_mailbox;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_stall;
  logic        tohost_we;
  logic [31:0] tohost_wdata;
  logic        tohost_full_stall;
  logic        host_tohost_valid;
  logic [31:0] host_tohost_data;
  logic        host_tohost_ready;
  logic        host_fromhost_valid;
  logic [31:0] host_fromhost_data;
  logic        host_fromhost_ready;
  logic        fromhost_we;
  logic [31:0] fromhost_wdata;
  logic [31:0] fromhost_value;
  logic        fromhost_irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_th[$];
  logic [31:0] exp_fh[$];

  always #5 clk = ~clk;

  htif_mailbox dut (
    .clk                 (clk),
    .reset               (reset),
    .core_stall          (core_stall),
    .tohost_we           (tohost_we),
    .tohost_wdata        (tohost_wdata),
    .tohost_full_stall   (tohost_full_stall),
    .host_tohost_valid   (host_tohost_valid),
    .host_tohost_data    (host_tohost_data),
    .host_tohost_ready   (host_tohost_ready),
    .host_fromhost_valid (host_fromhost_valid),
    .host_fromhost_data  (host_fromhost_data),
    .host_fromhost_ready (host_fromhost_ready),
    .fromhost_we         (fromhost_we),
    .fromhost_wdata      (fromhost_wdata),
    .fromhost_value      (fromhost_value),
    .fromhost_irq        (fromhost_irq)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Monitor: compares every host pop and every
  // committed FROMHOST write against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (host_tohost_valid && host_tohost_ready) begin
        if (exp_th.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL th_extra: got %h expected none",
                   host_tohost_data);
        end else
          chk("th_data", host_tohost_data,
              exp_th.pop_front());
      end
      if (fromhost_we && !core_stall) begin
        if (exp_fh.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fh_extra: got %h expected none",
                   fromhost_wdata);
        end else
          chk("fh_data", fromhost_wdata,
              exp_fh.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_th.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk(name, 32'(exp_th.size()), 32'd0);
  endtask

  logic [31:0] held;

  initial begin
    reset               = 1'b1;
    core_stall          = 1'b0;
    tohost_we           = 1'b0;
    tohost_wdata        = '0;
    host_tohost_ready   = 1'b0;
    host_fromhost_valid = 1'b0;
    host_fromhost_data  = '0;
    fromhost_value      = '0;
    tick();
    tick();
    at_neg();
    chk("rst_ready", 32'(host_fromhost_ready), 0);
    chk("rst_valid", 32'(host_tohost_valid), 0);
    chk("rst_we", 32'(fromhost_we), 0);
    chk("rst_wdata", fromhost_wdata, 0);
    chk("rst_irq", 32'(fromhost_irq), 0);
    tick();
    reset = 1'b0;
    at_neg();
    chk("post_rst_ready",
        32'(host_fromhost_ready), 1);
    chk("post_rst_stall",
        32'(tohost_full_stall), 0);

    // 1: single word, one-cycle latency
    tick();
    host_tohost_ready = 1'b1;
    tohost_we    = 1'b1;
    tohost_wdata = 32'h1;
    exp_th.push_back(32'h1);
    at_neg();
    chk("t1_valid_same", 32'(host_tohost_valid), 0);
    tick();
    tohost_we = 1'b0;
    at_neg();
    chk("t1_valid_next", 32'(host_tohost_valid), 1);
    tick();
    at_neg();
    chk("t1_valid_gone", 32'(host_tohost_valid), 0);

    // stalled core write must not push
    tick();
    core_stall   = 1'b1;
    tohost_we    = 1'b1;
    tohost_wdata = 32'hDEAD;
    tick();
    core_stall = 1'b0;
    tohost_we  = 1'b0;
    at_neg();
    chk("cs_no_push", 32'(host_tohost_valid), 0);

    // 2: fill to full, fifth write stalls
    tick();
    host_tohost_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tohost_we    = 1'b1;
      tohost_wdata = 32'h10 + 32'(i);
      at_neg();
      chk("t2_stall", 32'(tohost_full_stall),
          (i == 4) ? 32'd1 : 32'd0);
      if (i < 4) begin
        exp_th.push_back(tohost_wdata);
        tick();
      end
    end
    tick();
    host_tohost_ready = 1'b1;
    at_neg();
    chk("t2_stall_pop", 32'(tohost_full_stall), 1);
    tick();
    at_neg();
    chk("t2_stall_rel", 32'(tohost_full_stall), 0);
    exp_th.push_back(32'h14);
    tick();
    tohost_we = 1'b0;
    drain("t2_drain");

    // 3: full + pop + push in the same cycle
    host_tohost_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tohost_we    = 1'b1;
      tohost_wdata = 32'h20 + 32'(i);
      exp_th.push_back(tohost_wdata);
      tick();
    end
    tohost_wdata      = 32'h24;
    host_tohost_ready = 1'b1;
    at_neg();
    chk("t3_stall_full", 32'(tohost_full_stall), 1);
    tick();
    host_tohost_ready = 1'b0;
    at_neg();
    chk("t3_stall_rel", 32'(tohost_full_stall), 0);
    exp_th.push_back(32'h24);
    tick();
    tohost_wdata = 32'h99;
    at_neg();
    chk("t3_full_again", 32'(tohost_full_stall), 1);
    tick();
    tohost_we         = 1'b0;
    host_tohost_ready = 1'b1;
    drain("t3_drain");

    // 4: fromhost write held through core stall
    host_tohost_ready   = 1'b0;
    core_stall          = 1'b1;
    fromhost_value      = 32'hCAFE0001;
    host_fromhost_valid = 1'b1;
    host_fromhost_data  = 32'hCAFE0001;
    exp_fh.push_back(32'hCAFE0001);
    at_neg();
    chk("t4_ready_idle",
        32'(host_fromhost_ready), 1);
    tick();
    host_fromhost_valid = 1'b0;
    host_fromhost_data  = 32'h0BAD0BAD;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("t4_we_stall", 32'(fromhost_we), 1);
      chk("t4_data_hold", fromhost_wdata,
          32'hCAFE0001);
      chk("t4_ready_wr",
          32'(host_fromhost_ready), 0);
      tick();
    end
    core_stall = 1'b0;
    at_neg();
    chk("t4_we_commit", 32'(fromhost_we), 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("t4_irq", 32'(fromhost_irq), 1);
      chk("t4_we_off", 32'(fromhost_we), 0);
      chk("t4_ready_wait",
          32'(host_fromhost_ready), 0);
      tick();
    end
    fromhost_value = '0;
    at_neg();
    chk("t4_ready_clr0",
        32'(host_fromhost_ready), 0);
    tick();
    at_neg();
    chk("t4_ready_back",
        32'(host_fromhost_ready), 1);
    chk("t4_irq_off", 32'(fromhost_irq), 0);

    // 5: zero host word
    tick();
    host_fromhost_valid = 1'b1;
    host_fromhost_data  = 32'h0;
    exp_fh.push_back(32'h0);
    tick();
    host_fromhost_valid = 1'b0;
    at_neg();
    chk("t5_we", 32'(fromhost_we), 1);
    tick();
    at_neg();
    chk("t5_irq", 32'(fromhost_irq), 1);
    chk("t5_we_off", 32'(fromhost_we), 0);
    tick();
    at_neg();
    chk("t5_ready", 32'(host_fromhost_ready), 1);
    chk("t5_irq_off", 32'(fromhost_irq), 0);

    // 6: reset with FIFO words and FSM waiting
    tick();
    tohost_we    = 1'b1;
    tohost_wdata = 32'h30;
    tick();
    tohost_wdata = 32'h31;
    tick();
    tohost_we           = 1'b0;
    fromhost_value      = 32'h55;
    host_fromhost_valid = 1'b1;
    host_fromhost_data  = 32'h55;
    exp_fh.push_back(32'h55);
    tick();
    host_fromhost_valid = 1'b0;
    tick();
    at_neg();
    chk("t6_irq_pre", 32'(fromhost_irq), 1);
    chk("t6_valid_pre", 32'(host_tohost_valid), 1);
    held = host_tohost_data;
    chk("t6_head_pre", held, 32'h30);
    tick();
    reset = 1'b1;
    at_neg();
    chk("t6_ready_rst",
        32'(host_fromhost_ready), 0);
    tick();
    at_neg();
    chk("t6_valid_rst", 32'(host_tohost_valid), 0);
    chk("t6_irq_rst", 32'(fromhost_irq), 0);
    chk("t6_we_rst", 32'(fromhost_we), 0);
    tick();
    reset             = 1'b0;
    fromhost_value    = '0;
    host_tohost_ready = 1'b1;
    at_neg();
    chk("t6_ready_post",
        32'(host_fromhost_ready), 1);
    tick();
    at_neg();
    chk("t6_valid_post", 32'(host_tohost_valid), 0);

    chk("th_queue_left", 32'(exp_th.size()), 0);
    chk("fh_queue_left", 32'(exp_fh.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
